// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: operand issue / result capture controller around a pipelined
// sign-magnitude divider. It accepts one operand pair at a time and screens
// divide-by-zero and overflow before issue. It holds the operands on the divider
// for LAT cycles, then applies signs to the returned magnitudes.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | ready for a new operand pair (in_ready high)
//   RUN   | operands held on divider, counter running down to capture
//   DONE  | result/error held on outputs until consumer handshake
module div_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_dividend,
    input  logic [WIDTH:0]   in_divisor,
    output logic [WIDTH:0]   div_dividend,
    output logic [WIDTH:0]   div_divisor,
    input  logic [WIDTH:0]   div_result,
    input  logic [WIDTH:0]   div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_quotient,
    output logic [WIDTH:0]   out_remainder,
    output logic [1:0]       out_err
);

    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] COUNT_START = CW'(LAT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          accept;
    logic          dz;
    logic          ov;
    logic          capture;
    logic          unused_sign;

    // The divider only returns magnitudes; its sign bits carry no information.
    assign unused_sign = ^{div_result[WIDTH], div_remainder[WIDTH]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign capture   = (state == RUN) && (count == '0);

    // Error screening on magnitudes only, so -0 divisor also counts as zero.
    assign dz = (in_divisor[WIDTH-1:0] == '0);
    assign ov = !dz && (in_dividend[WIDTH-1:0] >= in_divisor[WIDTH-1:0]);

    // State sequencing and the issue-to-capture down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dz || ov) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                            count <= COUNT_START;
                        end
                    end
                end
                RUN: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Operand registers feeding the divider; held for the whole RUN interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_dividend <= '0;
            div_divisor  <= '0;
        end else if (accept) begin
            div_dividend <= in_dividend;
            div_divisor  <= in_divisor;
        end
    end

    // Result registers: error flags at accept, signed magnitudes at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_err       <= 2'b00;
        end else if (accept) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_err       <= {ov, dz};
        end else if (capture) begin
            // Zero magnitudes keep their computed sign; no -0 normalisation.
            out_quotient  <= {div_dividend[WIDTH] ^ div_divisor[WIDTH], div_result[WIDTH-1:0]};
            out_remainder <= {div_dividend[WIDTH], div_remainder[WIDTH-1:0]};
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed bench for div_seq_ctrl with an ideal divider model
// whose magnitudes become valid exactly LAT cycles after the operands change.
module tb_div_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int LAT   = 30;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_dividend;
    logic [WIDTH:0]   in_divisor;
    logic [WIDTH:0]   div_dividend;
    logic [WIDTH:0]   div_divisor;
    logic [WIDTH:0]   div_result;
    logic [WIDTH:0]   div_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_quotient;
    logic [WIDTH:0]   out_remainder;
    logic [1:0]       out_err;

    int n_cmp = 0;
    int n_bad = 0;

    div_seq_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_result    (div_result),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_err       (out_err)
    );

    always #5 clk = ~clk;

    // Ideal divider: garbage until LAT cycles after operands change, then exact.
    logic [2*WIDTH-1:0] m_num;
    logic [2*WIDTH-1:0] m_q;
    logic [2*WIDTH-1:0] m_r;
    logic [WIDTH:0]     m_prev_dd = '0;
    logic [WIDTH:0]     m_prev_dv = '0;
    int                 m_age = 0;
    always @(negedge clk) begin
        if (div_dividend !== m_prev_dd || div_divisor !== m_prev_dv) m_age = 1;
        else if (m_age < 1000) m_age = m_age + 1;
        m_prev_dd = div_dividend;
        m_prev_dv = div_divisor;
        m_num = {div_dividend[WIDTH-1:0], {WIDTH{1'b0}}};
        if (div_divisor[WIDTH-1:0] == '0) begin
            m_q = '0;
            m_r = '0;
        end else begin
            m_q = m_num / {{WIDTH{1'b0}}, div_divisor[WIDTH-1:0]};
            m_r = m_num % {{WIDTH{1'b0}}, div_divisor[WIDTH-1:0]};
        end
        if (m_age >= LAT) begin
            div_result    = {1'b0, m_q[WIDTH-1:0]};
            div_remainder = {1'b0, m_r[WIDTH-1:0]};
        end else begin
            div_result    = {1'b1, ~m_q[WIDTH-1:0]};
            div_remainder = {1'b1, ~m_r[WIDTH-1:0]};
        end
    end

    // Present one pair for one edge; caller must be in IDLE at #1 after an edge.
    task automatic accept(input logic [WIDTH:0] dd, input logic [WIDTH:0] dv);
        in_valid    = 1'b1;
        in_dividend = dd;
        in_divisor  = dv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_dividend = '0; in_divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_err, out_quotient, out_remainder, div_dividend, div_divisor} !== {1'b1, 1'b0, 2'b00, 36'h0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b q=%h r=%h dd=%h dv=%h, expected rdy=1 vld=0 all zero",
                     in_ready, out_valid, out_err, out_quotient, out_remainder, div_dividend, div_divisor);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_div_pos();
        int n;
        accept(9'h00B, 9'h015);
        n_cmp++;
        if ({in_ready, div_dividend, div_divisor} !== {1'b0, 9'h00B, 9'h015}) begin
            n_bad++;
            $display("FAIL pos_issue: got rdy=%b dd=%h dv=%h, expected rdy=0 dd=00b dv=015", in_ready, div_dividend, div_divisor);
        end
        wait_out(n);
        n_cmp++;
        if (n !== LAT) begin
            n_bad++;
            $display("FAIL pos_latency: got %0d edges, expected %0d", n, LAT);
        end
        n_cmp++;
        if ({out_quotient, out_remainder, out_err} !== {9'h086, 9'h002, 2'b00}) begin
            n_bad++;
            $display("FAIL pos_result: got q=%h r=%h err=%b, expected q=086 r=002 err=00", out_quotient, out_remainder, out_err);
        end
        consume();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL pos_handshake: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_div_neg();
        int n;
        accept(9'h10B, 9'h015);
        wait_out(n);
        n_cmp++;
        if ({out_quotient, out_remainder, out_err} !== {9'h186, 9'h102, 2'b00} || n !== LAT) begin
            n_bad++;
            $display("FAIL neg_result: got q=%h r=%h err=%b n=%0d, expected q=186 r=102 err=00 n=%0d", out_quotient, out_remainder, out_err, n, LAT);
        end
        consume();
        // Negative-zero dividend: zero magnitudes keep their computed signs.
        accept(9'h100, 9'h005);
        wait_out(n);
        n_cmp++;
        if ({out_quotient, out_remainder, out_err} !== {9'h100, 9'h100, 2'b00}) begin
            n_bad++;
            $display("FAIL neg_zero_sign: got q=%h r=%h err=%b, expected q=100 r=100 err=00", out_quotient, out_remainder, out_err);
        end
        consume();
    endtask

    task automatic test_div_zero();
        int n;
        accept(9'h005, 9'h100);
        wait_out(n);
        n_cmp++;
        if (n !== 0) begin
            n_bad++;
            $display("FAIL dz_latency: got %0d edges, expected 0", n);
        end
        n_cmp++;
        if ({out_err, out_quotient, out_remainder, div_divisor} !== {2'b01, 9'h000, 9'h000, 9'h100}) begin
            n_bad++;
            $display("FAIL dz_result: got err=%b q=%h r=%h dv=%h, expected err=01 q=000 r=000 dv=100", out_err, out_quotient, out_remainder, div_divisor);
        end
        consume();
        // 0/0: divide-by-zero takes precedence over overflow.
        accept(9'h000, 9'h000);
        n_cmp++;
        if ({out_valid, out_err} !== 3'b101) begin
            n_bad++;
            $display("FAIL dz_zero_over_zero: got vld=%b err=%b, expected vld=1 err=01", out_valid, out_err);
        end
        consume();
    endtask

    task automatic test_overflow();
        accept(9'h0B0, 9'h015);
        n_cmp++;
        if ({out_valid, out_err, out_quotient, out_remainder} !== {1'b1, 2'b10, 18'h0}) begin
            n_bad++;
            $display("FAIL ov_large: got vld=%b err=%b q=%h r=%h, expected vld=1 err=10 q=000 r=000", out_valid, out_err, out_quotient, out_remainder);
        end
        consume();
        accept(9'h015, 9'h115);
        n_cmp++;
        if ({out_valid, out_err} !== 3'b110) begin
            n_bad++;
            $display("FAIL ov_equal: got vld=%b err=%b, expected vld=1 err=10", out_valid, out_err);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int n;
        int bad_hold;
        accept(9'h004, 9'h008);
        wait_out(n);
        n_cmp++;
        if ({out_quotient, out_remainder, out_err} !== {9'h080, 9'h000, 2'b00}) begin
            n_bad++;
            $display("FAIL bp_first_result: got q=%h r=%h err=%b, expected q=080 r=000 err=00", out_quotient, out_remainder, out_err);
        end
        in_valid = 1'b1; in_dividend = 9'h003; in_divisor = 9'h105;
        out_ready = 1'b0;
        bad_hold = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if ({out_valid, in_ready, out_quotient, out_remainder, out_err, div_dividend} !== {1'b1, 1'b0, 9'h080, 9'h000, 2'b00, 9'h004})
                bad_hold++;
        end
        n_cmp++;
        if (bad_hold !== 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles, expected 0", bad_hold);
        end
        consume();
        n_cmp++;
        if ({in_ready, out_valid, div_dividend} !== {1'b1, 1'b0, 9'h004}) begin
            n_bad++;
            $display("FAIL bp_no_same_cycle_accept: got rdy=%b vld=%b dd=%h, expected rdy=1 vld=0 dd=004", in_ready, out_valid, div_dividend);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready, div_dividend, div_divisor} !== {1'b0, 9'h003, 9'h105}) begin
            n_bad++;
            $display("FAIL bp_second_accept: got rdy=%b dd=%h dv=%h, expected rdy=0 dd=003 dv=105", in_ready, div_dividend, div_divisor);
        end
        wait_out(n);
        n_cmp++;
        if ({out_quotient, out_remainder, out_err} !== {9'h199, 9'h003, 2'b00} || n !== LAT) begin
            n_bad++;
            $display("FAIL bp_second_result: got q=%h r=%h err=%b n=%0d, expected q=199 r=003 err=00 n=%0d", out_quotient, out_remainder, out_err, n, LAT);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int n;
        accept(9'h007, 9'h009);
        repeat (LAT - 6) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_pre_busy: got rdy=%b vld=%b, expected rdy=0 vld=0", in_ready, out_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_err, out_quotient, out_remainder, div_dividend, div_divisor} !== {1'b1, 1'b0, 2'b00, 36'h0}) begin
            n_bad++;
            $display("FAIL rst_mid_run: got rdy=%b vld=%b err=%b q=%h r=%h dd=%h dv=%h, expected rdy=1 vld=0 all zero",
                     in_ready, out_valid, out_err, out_quotient, out_remainder, div_dividend, div_divisor);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        accept(9'h001, 9'h003);
        wait_out(n);
        n_cmp++;
        if ({out_quotient, out_remainder, out_err} !== {9'h055, 9'h001, 2'b00} || n !== LAT) begin
            n_bad++;
            $display("FAIL rst_new_div: got q=%h r=%h err=%b n=%0d, expected q=055 r=001 err=00 n=%0d", out_quotient, out_remainder, out_err, n, LAT);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_div_pos();
        test_div_neg();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
